// File: rtl/fp_mul_sched.sv
// Two-requester scheduler for a shared LAT-stage pipelined FP multiplier, with result routing.
// Optional performance counters are enabled by defining FP_MUL_SCHED_PERF_EN.
module fp_mul_sched #(
   parameter int unsigned W   = 32,
   parameter int unsigned LAT = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   input  logic         req1_valid,
   output logic         req0_ready,
   output logic         req1_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         rsp0_valid,
   output logic         rsp1_valid,
   input  logic         rsp0_ready,
   input  logic         rsp1_ready,
   output logic [W-1:0] rsp_data,
   output logic [W-1:0] mul_a,
   output logic [W-1:0] mul_b,
   output logic         mul_stall,
   input  logic [W-1:0] mul_out,
   output logic [15:0]  perf_ops,
   output logic [15:0]  perf_stalls
);

   // Tracker mirrors the multiplier stages: one {valid, tag} per stage, tag 1 = req1.
   logic [LAT-1:0] vld_q;
   logic [LAT-1:0] tag_q;
   logic           rr_q;    // 1: req1 has priority on the next contended cycle
   logic           tail_ready;
   logic           gnt0;
   logic           gnt1;

   assign tail_ready = tag_q[LAT-1] ? rsp1_ready : rsp0_ready;
   assign mul_stall  = vld_q[LAT-1] & ~tail_ready;

   // Grants are masked by rst_n so nothing is accepted while reset is held.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n && !mul_stall) begin
         gnt0 = req0_valid & (~req1_valid | ~rr_q);
         gnt1 = req1_valid & (~req0_valid | rr_q);
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      if (gnt1) begin
         mul_a = req1_a;
         mul_b = req1_b;
      end else if (gnt0) begin
         mul_a = req0_a;
         mul_b = req0_b;
      end
   end

   assign rsp0_valid = vld_q[LAT-1] & ~tag_q[LAT-1];
   assign rsp1_valid = vld_q[LAT-1] & tag_q[LAT-1];
   assign rsp_data   = mul_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         tag_q <= '0;
         rr_q  <= 1'b0;
      end else if (!mul_stall) begin
         vld_q <= {vld_q[LAT-2:0], gnt0 | gnt1};
         tag_q <= {tag_q[LAT-2:0], gnt1};
         if (gnt0 || gnt1) begin
            rr_q <= gnt0;
         end
      end
   end

`ifdef FP_MUL_SCHED_PERF_EN
   logic [15:0] ops_q;
   logic [15:0] stalls_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ops_q    <= '0;
         stalls_q <= '0;
      end else begin
         if ((gnt0 || gnt1) && ops_q != 16'hFFFF) begin
            ops_q <= ops_q + 16'd1;
         end
         if (mul_stall && stalls_q != 16'hFFFF) begin
            stalls_q <= stalls_q + 16'd1;
         end
      end
   end

   assign perf_ops    = ops_q;
   assign perf_stalls = stalls_q;
`else
   assign perf_ops    = '0;
   assign perf_stalls = '0;
`endif

endmodule

// File: doc/fp_mul_sched.md
FP_MUL_SCHED -- requirements
Module: fp_mul_sched

Interface
REQ-001 Parameter: W, 32, operand/result width (IEEE-754 single).
REQ-002 Parameter: LAT, 3, multiplier pipeline depth in non-stalled clock edges.
REQ-003 The block SHALL provide clk  input  1  clock, all state updates on rising edge.
REQ-004 The block SHALL provide rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL provide req0_valid / req1_valid  input  1  requester has an operand pair.
REQ-006 The block SHALL provide req0_ready / req1_ready  output  1  operand pair accepted this cycle.
REQ-007 The block SHALL provide req0_a, req0_b, req1_a, req1_b  input  W  operands.
REQ-008 The block SHALL provide rsp0_valid / rsp1_valid  output  1  result available to requester.
REQ-009 The block SHALL provide rsp0_ready / rsp1_ready  input  1  requester consumes result.
REQ-010 The block SHALL provide rsp_data  output  W  result, shared, meaningful only with rspN_valid.
REQ-011 The block SHALL provide mul_a, mul_b  output  W  operands to the multiplier.
REQ-012 The block SHALL provide mul_stall  output  1  freezes all multiplier stages.
REQ-013 The block SHALL provide mul_out  input  W  multiplier result.
REQ-014 The block SHALL provide perf_ops, perf_stalls  output  16  performance counters.

Function
REQ-015 Tracker: LAT-deep shift register of {valid, tag}; advances only on edges where mul_stall=0, in lockstep with the multiplier.
REQ-016 mul_stall SHALL equal valid[LAT-1] AND NOT rsp_ready[tag[LAT-1]], combinationally.
REQ-017 rspN_valid SHALL be valid[LAT-1] AND tag[LAT-1]==N; rsp_data SHALL equal mul_out.
REQ-018 Arbitration: when mul_stall=0, grant one valid requester; if both valid, grant the one not granted last (round-robin pointer, reset to favour req0).
REQ-019 reqN_ready SHALL be high only for the granted requester and only while mul_stall=0; never both high.
REQ-020 mul_a/mul_b SHALL carry the granted requester's operands; with no grant they SHALL be 0 and a bubble (valid=0) enters stage 0.
REQ-021 Round-robin pointer SHALL update only on an accepted transfer (valid & ready).
REQ-022 Latency: operands accepted at edge k produce rsp valid LAT cycles later absent stalls; each stall cycle adds one.
REQ-023 Results SHALL return in acceptance order; none dropped or duplicated.
REQ-024 Full occupancy: back-to-back acceptance every non-stalled cycle, throughput 1 op/cycle.
REQ-025 Simultaneous output-retire and input-accept in one cycle SHALL be allowed (pipeline shifts).
REQ-026 A stalled requester's own new request SHALL not be accepted while its result blocks the pipe; the other requester also waits (single shared pipe).

Reset
REQ-027 On rst_n low: all tracker valid bits 0, round-robin pointer to req0, counters 0.
REQ-028 During and after reset: reqN_ready=0 while rst_n low, rspN_valid=0, mul_stall=0, mul_a=mul_b=0.
REQ-029 Reset mid-operation SHALL discard all in-flight results; no rsp_valid after release until new requests complete.

Configuration
REQ-030 Macro FP_MUL_SCHED_PERF_EN: when defined, perf_ops counts accepted requests and perf_stalls counts cycles with mul_stall=1, both saturating at 16'hFFFF.
REQ-031 Without FP_MUL_SCHED_PERF_EN, perf_ops and perf_stalls SHALL be constant 0 and no counter flops exist.

Verification
REQ-032 Single op: req0 a=0x40000000, b=0x40400000 -> rsp0_valid 3 cycles later, rsp_data=0x40C00000, rsp1_valid=0.
REQ-033 Contention: both valid same cycle, req0 1.5*1.5 (0x3FC00000), req1 -2*4 (0xC0000000, 0x40800000) -> req0 granted first; rsp0 0x40100000 then rsp1 0xC1000000 on consecutive cycles.
REQ-034 Backpressure: 3 ops back-to-back from req1, rsp1_ready low 5 cycles at first result -> mul_stall high 5 cycles, req_ready low throughout, all 3 results delivered in order, perf_stalls=5 (macro on).
REQ-035 Fairness: both requesters continuously valid for 10 cycles -> grants alternate 0,1,0,1..., 5 each.
REQ-036 Reset mid-flight: assert rst_n low with 2 ops in flight -> after release no rsp_valid, counters 0, next op completes normally.
REQ-037 Macro off build: run REQ-034 stimulus -> perf_ops=perf_stalls=0, functional results identical.
